instr_sram_sched: RTL and testbench
===================================

INSTR_SRAM_SCHED -- requirements
Module: instr_sram_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning SRAM word width; one instruction is 2*DATA_W bits.
REQ-003 SHALL have ports as follows; reset is synchronous, active-high:
- CLK  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- wr_valid  in  1  loader write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_addr  in  ADDR_W  SRAM word address
- wr_data  in  DATA_W  write word
- fetch_valid  in  1  instruction fetch request
- fetch_ready  out  1  fetch accepted when fetch_valid & fetch_ready
- fetch_ptr  in  ADDR_W-1  instruction index; words 2*ptr and 2*ptr+1
- instr_valid  out  1  one-cycle response strobe
- instr_data  out  2*DATA_W  {word 2*ptr+1, word 2*ptr}
- sram_cen  out  1  SRAM chip enable, active-low
- sram_gwen  out  1  0 write, 1 read
- sram_a  out  ADDR_W  SRAM address
- sram_d  out  DATA_W  SRAM write data
- sram_q  in  DATA_W  SRAM read data, valid the cycle after a read cycle

Function
REQ-004 SHALL use FSM states IDLE, WR, RD_LO, RD_HI, RESP; all SRAM pins are registered.
REQ-005 SHALL assert wr_ready and fetch_ready only in IDLE, and only for the granted requester.
REQ-006 SHALL arbitrate round-robin when both are valid in IDLE: grant the class not granted last; a lone requester is always granted.
REQ-007 Write accepted in cycle N SHALL drive sram_cen=0, sram_gwen=0, sram_a=wr_addr, sram_d=wr_data in N+1 (state WR), then return to IDLE in N+2.
REQ-008 Fetch accepted in cycle N SHALL read 2*ptr in N+1 (RD_LO), read 2*ptr+1 in N+2 (RD_HI), capture sram_q in N+2 (low) and N+3 (high), and assert instr_valid in N+4 (RESP).
REQ-009 instr_valid SHALL be high exactly one cycle per response; instr_data SHALL hold its value until the next response.
REQ-010 In any cycle without an SRAM access, sram_cen=1 and sram_gwen=1; sram_a and sram_d hold their last value.
REQ-011 SHALL issue at most one SRAM access per cycle and never a write during RD_LO/RD_HI.
REQ-012 Address arithmetic SHALL be modulo 2^ADDR_W; fetch_ptr is ADDR_W-1 bits, so 2*ptr+1 never overflows.
REQ-013 Request inputs SHALL be sampled only in the accept cycle; later changes have no effect.

Reset
REQ-014 On rst: state=IDLE, sram_cen=1, sram_gwen=1, sram_a=0, sram_d=0, instr_valid=0, instr_data=0, round-robin last-grant=fetch (write wins first tie).
REQ-015 rst mid-operation SHALL abort the transaction in the next cycle with no instr_valid, and SHALL leave no pending SRAM write.

Configuration
REQ-016 Macro INSTR_PREFETCH_EN defined: one-entry prefetch buffer (pf_data, pf_ptr, pf_valid). After each RESP, if IDLE has no valid request, SHALL read ptr+1 (wraps 2^(ADDR_W-1)-1 to 0) into the buffer using RD_LO/RD_HI; a request arriving meanwhile waits.
REQ-017 With INSTR_PREFETCH_EN, a fetch with pf_valid and fetch_ptr==pf_ptr SHALL respond with instr_valid in N+1 without SRAM access, then prefetch fetch_ptr+1.
REQ-018 With INSTR_PREFETCH_EN, a write to 2*pf_ptr or 2*pf_ptr+1, including one accepted during a prefetch, SHALL clear pf_valid.
REQ-019 Macro undefined: no buffer, every fetch follows REQ-008, and the SRAM stays idle while no request is valid.

Verification
REQ-020 Write addr 0x004 data 0x1111, addr 0x005 data 0x2222, then fetch ptr 2 -> instr_valid at acceptance+4, instr_data=0x0000000000002222_0000000000001111.
REQ-021 wr_valid and fetch_valid held high from reset -> grants alternate write, fetch, write; cen never low on two requests in the same cycle.
REQ-022 Fetch ptr 255 -> sram_a=0x1FE then 0x1FF; with INSTR_PREFETCH_EN the following prefetch reads 0x000 and 0x001.
REQ-023 rst asserted in RD_HI -> next cycle sram_cen=1, state IDLE, no instr_valid.
REQ-024 With INSTR_PREFETCH_EN: fetch ptr 7, idle 4 cycles, fetch ptr 8 -> response at acceptance+1; repeat after writing addr 0x012 -> pf_valid cleared, response at acceptance+4 with the new data.

Source files
------------

// File: rtl/instr_sram_sched.sv
// Instruction fetch/load scheduler for a single-port SRAM: 2-word fetches, loader writes, RR arbitration.
// Fetch resp at accept+4 (prefetch hit +1 with INSTR_PREFETCH_EN); write issues at accept+1; ready only in IDLE.
module instr_sram_sched #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                fetch_valid,
  output logic                fetch_ready,
  input  logic [ADDR_W-2:0]   fetch_ptr,
  output logic                instr_valid,
  output logic [2*DATA_W-1:0] instr_data,
  output logic                sram_cen,
  output logic                sram_gwen,
  output logic [ADDR_W-1:0]   sram_a,
  output logic [DATA_W-1:0]   sram_d,
  input  logic [DATA_W-1:0]   sram_q
);

  localparam int PW = ADDR_W - 1;

  typedef enum logic [2:0] {IDLE, WR, RD_LO, RD_HI, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_fetch_q, last_fetch_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                sram_cen_q, sram_cen_d;
  logic                sram_gwen_q, sram_gwen_d;
  logic [ADDR_W-1:0]   sram_a_q, sram_a_d;
  logic [DATA_W-1:0]   sram_d_q, sram_d_d;
  logic                instr_valid_q, instr_valid_d;
  logic [2*DATA_W-1:0] instr_data_q, instr_data_d;

`ifdef INSTR_PREFETCH_EN
  logic [2*DATA_W-1:0] pf_data_q, pf_data_d;
  logic [PW-1:0]       pf_ptr_q, pf_ptr_d;
  logic                pf_valid_q, pf_valid_d;
  logic                pf_pend_q, pf_pend_d;
  logic [PW-1:0]       pf_next_q, pf_next_d;
  logic                pf_rd_q, pf_rd_d;
  logic                pf_hit;
`endif

  logic idle;
  logic grant_wr;
  logic grant_fe;

  // On a tie the class that did not win last time is granted.
  assign idle     = (state_q == IDLE);
  assign grant_wr = idle & wr_valid & (~fetch_valid | last_fetch_q);
  assign grant_fe = idle & fetch_valid & (~wr_valid | ~last_fetch_q);

  assign wr_ready    = grant_wr;
  assign fetch_ready = grant_fe;
  assign instr_valid = instr_valid_q;
  assign instr_data  = instr_data_q;
  assign sram_cen    = sram_cen_q;
  assign sram_gwen   = sram_gwen_q;
  assign sram_a      = sram_a_q;
  assign sram_d      = sram_d_q;

`ifdef INSTR_PREFETCH_EN
  assign pf_hit = pf_valid_q & (fetch_ptr == pf_ptr_q);
`endif

  always_comb begin
    state_d       = state_q;
    last_fetch_d  = last_fetch_q;
    rd_ptr_d      = rd_ptr_q;
    lo_d          = lo_q;
    sram_cen_d    = 1'b1;
    sram_gwen_d   = 1'b1;
    sram_a_d      = sram_a_q;
    sram_d_d      = sram_d_q;
    instr_valid_d = 1'b0;
    instr_data_d  = instr_data_q;
`ifdef INSTR_PREFETCH_EN
    pf_data_d  = pf_data_q;
    pf_ptr_d   = pf_ptr_q;
    pf_valid_d = pf_valid_q;
    pf_pend_d  = pf_pend_q;
    pf_next_d  = pf_next_q;
    pf_rd_d    = pf_rd_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d      = WR;
          last_fetch_d = 1'b0;
          sram_cen_d   = 1'b0;
          sram_gwen_d  = 1'b0;
          sram_a_d     = wr_addr;
          sram_d_d     = wr_data;
`ifdef INSTR_PREFETCH_EN
          pf_pend_d = 1'b0;
          if (wr_addr[ADDR_W-1:1] == pf_ptr_q) pf_valid_d = 1'b0;
`endif
        end else if (grant_fe) begin
          last_fetch_d = 1'b1;
`ifdef INSTR_PREFETCH_EN
          if (pf_hit) begin
            instr_valid_d = 1'b1;
            instr_data_d  = pf_data_q;
            pf_pend_d     = 1'b1;
            pf_next_d     = fetch_ptr + 1'b1;
          end else begin
            state_d    = RD_LO;
            rd_ptr_d   = fetch_ptr;
            sram_cen_d = 1'b0;
            sram_a_d   = {fetch_ptr, 1'b0};
            pf_rd_d    = 1'b0;
            pf_pend_d  = 1'b0;
          end
`else
          state_d    = RD_LO;
          rd_ptr_d   = fetch_ptr;
          sram_cen_d = 1'b0;
          sram_a_d   = {fetch_ptr, 1'b0};
`endif
        end
`ifdef INSTR_PREFETCH_EN
        else if (pf_pend_q) begin
          // Buffer is invalid while being refilled; it revalidates in RESP.
          state_d    = RD_LO;
          rd_ptr_d   = pf_next_q;
          sram_cen_d = 1'b0;
          sram_a_d   = {pf_next_q, 1'b0};
          pf_rd_d    = 1'b1;
          pf_pend_d  = 1'b0;
          pf_valid_d = 1'b0;
          pf_ptr_d   = pf_next_q;
        end
`endif
      end
      WR: begin
        state_d = IDLE;
      end
      RD_LO: begin
        state_d    = RD_HI;
        sram_cen_d = 1'b0;
        sram_a_d   = {rd_ptr_q, 1'b1};
      end
      RD_HI: begin
        state_d = RESP;
        lo_d    = sram_q;
      end
      RESP: begin
        state_d = IDLE;
`ifdef INSTR_PREFETCH_EN
        if (pf_rd_q) begin
          pf_data_d  = {sram_q, lo_q};
          pf_valid_d = 1'b1;
        end else begin
          instr_valid_d = 1'b1;
          instr_data_d  = {sram_q, lo_q};
          pf_pend_d     = 1'b1;
          pf_next_d     = rd_ptr_q + 1'b1;
        end
`else
        instr_valid_d = 1'b1;
        instr_data_d  = {sram_q, lo_q};
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q       <= IDLE;
      last_fetch_q  <= 1'b1;
      rd_ptr_q      <= '0;
      lo_q          <= '0;
      sram_cen_q    <= 1'b1;
      sram_gwen_q   <= 1'b1;
      sram_a_q      <= '0;
      sram_d_q      <= '0;
      instr_valid_q <= 1'b0;
      instr_data_q  <= '0;
`ifdef INSTR_PREFETCH_EN
      pf_data_q  <= '0;
      pf_ptr_q   <= '0;
      pf_valid_q <= 1'b0;
      pf_pend_q  <= 1'b0;
      pf_next_q  <= '0;
      pf_rd_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      last_fetch_q  <= last_fetch_d;
      rd_ptr_q      <= rd_ptr_d;
      lo_q          <= lo_d;
      sram_cen_q    <= sram_cen_d;
      sram_gwen_q   <= sram_gwen_d;
      sram_a_q      <= sram_a_d;
      sram_d_q      <= sram_d_d;
      instr_valid_q <= instr_valid_d;
      instr_data_q  <= instr_data_d;
`ifdef INSTR_PREFETCH_EN
      pf_data_q  <= pf_data_d;
      pf_ptr_q   <= pf_ptr_d;
      pf_valid_q <= pf_valid_d;
      pf_pend_q  <= pf_pend_d;
      pf_next_q  <= pf_next_d;
      pf_rd_q    <= pf_rd_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_sram_sched.sv
// Scoreboard bench for instr_sram_sched with a behavioural SRAM; works with or without INSTR_PREFETCH_EN.
module tb_instr_sram_sched;

`ifdef INSTR_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         wr_valid;
  logic         wr_ready;
  logic [8:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         fetch_valid;
  logic         fetch_ready;
  logic [7:0]   fetch_ptr;
  logic         instr_valid;
  logic [127:0] instr_data;
  logic         sram_cen;
  logic         sram_gwen;
  logic [8:0]   sram_a;
  logic [63:0]  sram_d;
  logic [63:0]  sram_q;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  instr_sram_sched #(.ADDR_W(9), .DATA_W(64)) dut (
    .CLK(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_ptr(fetch_ptr),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_a(sram_a), .sram_d(sram_d),
    .sram_q(sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten words read back as C0DE_0000_0000_0000 | address.
  bit [63:0] mem  [512];
  bit        seen [512];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        mem[sram_a]  <= sram_d;
        seen[sram_a] <= 1'b1;
      end else begin
        sram_q <= seen[sram_a] ? mem[sram_a] : (64'hC0DE_0000_0000_0000 | 64'(sram_a));
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && instr_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL resp_unexpected: got data %0h at cycle %0d, none expected", instr_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("resp_data", instr_data, mon_e.data);
        check("resp_cycle", 128'(cyc), 128'(mon_e.cyc));
      end
    end
  end

  task automatic do_write(input logic [8:0] a, input logic [63:0] d, input bit chk);
    int n;
    n = 0;
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    while (!wr_ready && n < 100) begin n++; @(negedge clk); end
    check("wr_accept", 128'(wr_ready), 128'(1));
    @(posedge clk); #1;
    wr_valid = 1'b0;
    if (chk) begin
      @(negedge clk);
      check("wr_cen", 128'(sram_cen), 128'(0));
      check("wr_gwen", 128'(sram_gwen), 128'(0));
      check("wr_a", 128'(sram_a), 128'(a));
      check("wr_d", 128'(sram_d), 128'(d));
      @(negedge clk);
      check("wr_after_cen", 128'(sram_cen), 128'(1));
      check("wr_after_gwen", 128'(sram_gwen), 128'(1));
      check("wr_after_a_hold", 128'(sram_a), 128'(a));
      check("wr_after_d_hold", 128'(sram_d), 128'(d));
    end
  endtask

  task automatic do_fetch(input logic [7:0] p, input logic [127:0] exp, input int lat, input bit push);
    int   n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    fetch_valid = 1'b1; fetch_ptr = p;
    @(negedge clk);
    while (!fetch_ready && n < 100) begin n++; @(negedge clk); end
    check("fetch_accept", 128'(fetch_ready), 128'(1));
    if (push) begin
      e.data = exp;
      e.cyc  = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    fetch_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin n++; @(negedge clk); end
    check("drain", 128'(sb.size()), 128'(0));
  endtask

  bit grants[$];
  int both;
  bit [8:0]  tr_a   [1:6];
  bit        tr_cen [1:6];

  initial begin
    rst = 1'b1; wr_valid = 1'b0; fetch_valid = 1'b0;
    wr_addr = '0; wr_data = '0; fetch_ptr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cen", 128'(sram_cen), 128'(1));
    check("rst_gwen", 128'(sram_gwen), 128'(1));
    check("rst_a", 128'(sram_a), 128'(0));
    check("rst_d", 128'(sram_d), 128'(0));
    check("rst_instr_valid", 128'(instr_valid), 128'(0));
    check("rst_instr_data", instr_data, 128'(0));
    check("rst_wr_ready", 128'(wr_ready), 128'(0));
    check("rst_fetch_ready", 128'(fetch_ready), 128'(0));

    // Basic load then fetch
    do_write(9'h004, 64'h1111, 1'b1);
    do_write(9'h005, 64'h2222, 1'b0);
    do_fetch(8'd2, 128'h0000000000002222_0000000000001111, 4, 1'b1);
    drain();

    // Top-of-memory fetch and wrapped prefetch address
    do_write(9'h1FE, 64'hABCD, 1'b0);
    do_write(9'h1FF, 64'h1234, 1'b0);
    do_fetch(8'd255, 128'h0000000000001234_000000000000ABCD, 4, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      tr_a[k]   = sram_a;
      tr_cen[k] = sram_cen;
    end
    check("ptr255_cen1", 128'(tr_cen[1]), 128'(0));
    check("ptr255_a1", 128'(tr_a[1]), 128'(9'h1FE));
    check("ptr255_cen2", 128'(tr_cen[2]), 128'(0));
    check("ptr255_a2", 128'(tr_a[2]), 128'(9'h1FF));
    check("ptr255_cen3", 128'(tr_cen[3]), 128'(1));
    check("ptr255_cen5", 128'(tr_cen[5]), 128'(PF ? 0 : 1));
    check("ptr255_a5", 128'(tr_a[5]), 128'(PF ? 9'h000 : 9'h1FF));
    check("ptr255_cen6", 128'(tr_cen[6]), 128'(PF ? 0 : 1));
    check("ptr255_a6", 128'(tr_a[6]), 128'(PF ? 9'h001 : 9'h1FF));
    drain();

    // Prefetch hit, then invalidation by a write into the buffered line
    do_fetch(8'd7, 128'hC0DE00000000000F_C0DE00000000000E, 4, 1'b1);
    drain();
    repeat (6) @(posedge clk);
    do_fetch(8'd8, 128'hC0DE000000000011_C0DE000000000010, PF ? 1 : 4, 1'b1);
    @(negedge clk);
    check("ptr8_cen_next", 128'(sram_cen), 128'(PF ? 1 : 0));
    drain();
    repeat (6) @(posedge clk);
    do_write(9'h012, 64'h5555, 1'b0);
    do_fetch(8'd9, 128'hC0DE000000000013_0000000000005555, 4, 1'b1);
    drain();
    repeat (8) @(posedge clk);

    // Both requesters held from reset: grants alternate write, fetch, ...
    @(posedge clk); #1;
    rst = 1'b1;
    wr_valid = 1'b1; wr_addr = 9'h020; wr_data = 64'h77;
    fetch_valid = 1'b1; fetch_ptr = 8'h10;
    @(posedge clk); #1;
    rst = 1'b0;
    both = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wr_ready && fetch_ready) both++;
      if (wr_ready) grants.push_back(1'b0);
      if (fetch_ready) begin
        grants.push_back(1'b1);
        mon_e.data = 128'hC0DE000000000021_0000000000000077;
        mon_e.cyc  = cyc + 4;
        sb.push_back(mon_e);
      end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0; fetch_valid = 1'b0;
    check("rr_both_ready", 128'(both), 128'(0));
    check("rr_grant_count", 128'(grants.size() >= 3), 128'(1));
    for (int i = 0; i < grants.size(); i++)
      check("rr_grant_order", 128'(grants[i]), 128'(i % 2));
    drain();
    repeat (8) @(posedge clk);

    // Reset during RD_HI aborts the fetch
    do_fetch(8'h30, 128'h0, 0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_rdhi_cen", 128'(sram_cen), 128'(0));
    check("abort_rdhi_a", 128'(sram_a), 128'(9'h061));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_cen", 128'(sram_cen), 128'(1));
    check("abort_gwen", 128'(sram_gwen), 128'(1));
    check("abort_instr_valid", 128'(instr_valid), 128'(0));
    @(negedge clk);
    check("abort_instr_valid2", 128'(instr_valid), 128'(0));
    repeat (6) @(negedge clk);
    check("abort_no_late_resp", 128'(instr_valid), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
